// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Arbitrates an instruction port and a data port onto one
//               single-outstanding memory port, with I-side anti-starvation
//               and a WAIT-state timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT_CYC  = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_be,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        m_req,
    output logic        m_we,
    output logic [3:0]  m_be,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_gnt,
    input  logic        m_rvalid,
    input  logic [31:0] m_rdata,
    output logic        busy,
    output logic        err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    localparam logic [3:0] c_STARVE_MAX = 4'(STARVE_LIMIT);
    localparam logic [9:0] c_TMO_LAST   = 10'(TIMEOUT_CYC - 1);

    logic [1:0] r_state;
    logic [1:0] w_next_state;
    logic       r_owner_i;
    logic [3:0] r_starve_cnt;
    logic [9:0] r_tmo_cnt;

    logic w_pick_i;
    logic w_mem_gnt;
    logic w_mem_done;
    logic w_tmo_fire;

    // I only wins a contested slot once D has won STARVE_LIMIT times in a row
    assign w_pick_i   = i_req && (!d_req || (r_starve_cnt == c_STARVE_MAX));
    assign w_mem_gnt  = (r_state == S_ISSUE) && m_gnt;
    assign w_mem_done = (r_state == S_WAIT) && m_rvalid;
    assign w_tmo_fire = (r_state == S_WAIT) && !m_rvalid && (r_tmo_cnt == c_TMO_LAST);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (i_req || d_req) w_next_state = S_ISSUE;
            S_ISSUE: if (m_gnt) w_next_state = S_WAIT;
            S_WAIT:  if (m_rvalid || w_tmo_fire) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_owner_i    <= 1'b0;
            r_starve_cnt <= 4'd0;
            r_tmo_cnt    <= 10'd0;
        end else begin
            r_state <= w_next_state;
            if ((r_state == S_IDLE) && (i_req || d_req)) begin
                r_owner_i <= w_pick_i;
                if (w_pick_i)
                    r_starve_cnt <= 4'd0;
                else if (i_req && (r_starve_cnt != c_STARVE_MAX))
                    r_starve_cnt <= r_starve_cnt + 4'd1;
            end
            if (w_mem_gnt)
                r_tmo_cnt <= 10'd0;
            else if ((r_state == S_WAIT) && !m_rvalid)
                r_tmo_cnt <= r_tmo_cnt + 10'd1;
        end
    end

    always_comb begin
        m_req   = 1'b0;
        m_we    = 1'b0;
        m_be    = 4'h0;
        m_addr  = 32'h0;
        m_wdata = 32'h0;
        if (r_state == S_ISSUE) begin
            m_req = 1'b1;
            if (r_owner_i) begin
                m_be   = 4'hF;
                m_addr = i_addr;
            end else begin
                m_we    = d_we;
                m_be    = d_be;
                m_addr  = d_addr;
                m_wdata = d_wdata;
            end
        end
    end

    // A timeout completes the owner with zero data; a real response wins a tie
    assign i_gnt    = w_mem_gnt && r_owner_i;
    assign d_gnt    = w_mem_gnt && !r_owner_i;
    assign i_rvalid = (w_mem_done || w_tmo_fire) && r_owner_i;
    assign d_rvalid = (w_mem_done || w_tmo_fire) && !r_owner_i;
    assign i_rdata  = (w_mem_done && r_owner_i) ? m_rdata : 32'h0;
    assign d_rdata  = (w_mem_done && !r_owner_i) ? m_rdata : 32'h0;
    assign busy     = (r_state != S_IDLE);
    assign err      = w_tmo_fire;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Scoreboard bench for mem_port_arbiter: directed stimulus
//               pushes expected grants/responses, a monitor pops and checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        i_gnt, i_rvalid;
    logic [31:0] i_rdata;
    logic        d_req = 1'b0, d_we = 1'b0;
    logic [3:0]  d_be = '0;
    logic [31:0] d_addr = '0, d_wdata = '0;
    logic        d_gnt, d_rvalid;
    logic [31:0] d_rdata;
    logic        m_req, m_we;
    logic [3:0]  m_be;
    logic [31:0] m_addr, m_wdata;
    logic        m_gnt, m_rvalid;
    logic [31:0] m_rdata;
    logic        busy, err;

    // memory side: either hand-driven or an always-ready auto responder
    logic        mem_auto = 1'b0;
    logic        man_gnt = 1'b0, man_rvalid = 1'b0;
    logic [31:0] man_rdata = '0;
    logic        a_rvalid = 1'b0;
    logic [31:0] a_rdata = '0;
    bit          hs = 1'b0;
    logic [31:0] hs_addr = '0;

    assign m_gnt    = mem_auto ? 1'b1 : man_gnt;
    assign m_rvalid = mem_auto ? a_rvalid : man_rvalid;
    assign m_rdata  = mem_auto ? a_rdata : man_rdata;

    mem_port_arbiter #(.STARVE_LIMIT(4), .TIMEOUT_CYC(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_i;
        logic [31:0] data;
        bit          chk_data;
        bit          err;
    } rsp_t;

    rsp_t rsp_q[$];
    bit   gnt_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_gnt_seen = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: event seen with nothing expected (t=%0t)", name, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // auto responder: answer one cycle after a handshake, data derived from address
    always @(negedge clk) begin
        hs      = m_req && m_gnt;
        hs_addr = m_addr;
    end
    always @(posedge clk) begin
        #1;
        a_rvalid = mem_auto && hs;
        a_rdata  = hs ? (hs_addr ^ 32'hA5A5_0000) : 32'h0;
    end

    // monitor: pops expected grants/responses whenever the DUT presents one
    always @(negedge clk) begin
        if (rst_n) begin
            if (i_gnt || d_gnt) begin
                n_gnt_seen++;
                if (gnt_q.size() == 0) fail_now("gnt_unexpected");
                else begin
                    bit g;
                    g = gnt_q.pop_front();
                    check("gnt_owner", {62'd0, i_gnt, d_gnt}, g ? 64'd2 : 64'd1);
                end
            end
            if (i_rvalid || d_rvalid) begin
                if (rsp_q.size() == 0) fail_now("rvalid_unexpected");
                else begin
                    rsp_t r;
                    r = rsp_q.pop_front();
                    check("rvalid_owner", {62'd0, i_rvalid, d_rvalid}, r.is_i ? 64'd2 : 64'd1);
                    if (r.chk_data)
                        check("rdata", {32'd0, r.is_i ? i_rdata : d_rdata}, {32'd0, r.data});
                    check("nonowner_rdata", {32'd0, r.is_i ? d_rdata : i_rdata}, 64'd0);
                    check("err_flag", {63'd0, err}, {63'd0, r.err});
                end
            end else if (err) begin
                fail_now("err_without_rvalid");
            end
        end
    end

    initial begin
        rsp_t r;
        #3;
        check("reset_outputs_zero",
              {63'd0, |{i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
                        m_req, m_we, m_be, m_addr, m_wdata, busy, err}}, 64'd0);
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;

        // single I fetch, memory ready immediately, response after one cycle
        man_gnt = 1'b1;
        gnt_q.push_back(1'b1);
        r = '{1'b1, 32'hDEADBEEF, 1'b1, 1'b0};
        rsp_q.push_back(r);
        step(); i_req = 1'b1; i_addr = 32'h100;
        @(negedge clk); check("c0_busy", {63'd0, busy}, 64'd0);
        step();
        @(negedge clk);
        check("c1_busy", {63'd0, busy}, 64'd1);
        check("c1_i_gnt", {63'd0, i_gnt}, 64'd1);
        check("c1_m_fields", {27'd0, m_req, m_we, m_be, m_addr}, {27'd0, 1'b1, 1'b0, 4'hF, 32'h100});
        step(); i_req = 1'b0; man_rvalid = 1'b1; man_rdata = 32'hDEADBEEF;
        @(negedge clk); check("c2_busy", {63'd0, busy}, 64'd1);
        step(); man_rvalid = 1'b0;
        @(negedge clk); check("c3_busy", {63'd0, busy}, 64'd0);

        // both sides held, memory always ready: starvation fairness order
        n_gnt_seen = 0;
        for (int k = 0; k < 10; k++) begin
            bit is_i;
            is_i = (k == 4) || (k == 9);
            gnt_q.push_back(is_i);
            r = '{is_i, is_i ? 32'hA5A5_0300 : 32'hA5A5_0200, 1'b1, 1'b0};
            rsp_q.push_back(r);
        end
        mem_auto = 1'b1;
        i_addr = 32'h300; i_req = 1'b1;
        d_addr = 32'h200; d_we = 1'b0; d_be = 4'hF; d_req = 1'b1;
        for (int c = 0; c < 80 && n_gnt_seen < 10; c++) @(posedge clk);
        #1 i_req = 1'b0; d_req = 1'b0;
        check("fair_grant_count", 64'(n_gnt_seen), 64'd10);
        repeat (3) step();
        mem_auto = 1'b0;
        man_gnt = 1'b0;

        // store stalled by memory for five cycles
        gnt_q.push_back(1'b0);
        r = '{1'b0, 32'h0, 1'b0, 1'b0};
        rsp_q.push_back(r);
        step(); d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 32'h40; d_wdata = 32'h1234;
        @(negedge clk); check("st_idle_m_req", {63'd0, m_req}, 64'd0);
        for (int k = 1; k <= 5; k++) begin
            step();
            @(negedge clk);
            check("st_stall_fields", {22'd0, m_req, m_we, m_be, m_addr[15:0], m_wdata},
                  {22'd0, 1'b1, 1'b1, 4'b0011, 16'h0040, 32'h1234});
            check("st_stall_no_gnt", {63'd0, d_gnt}, 64'd0);
        end
        step(); man_gnt = 1'b1;
        @(negedge clk); check("st_gnt_6th", {63'd0, d_gnt}, 64'd1);
        step(); d_req = 1'b0; d_we = 1'b0; man_gnt = 1'b0; man_rvalid = 1'b1; man_rdata = 32'h55;
        step(); man_rvalid = 1'b0;

        // D load that never completes: timeout in the 8th WAIT cycle
        gnt_q.push_back(1'b0);
        r = '{1'b0, 32'h0, 1'b1, 1'b1};
        rsp_q.push_back(r);
        step(); d_req = 1'b1; d_be = 4'hF; d_addr = 32'h80;
        step(); man_gnt = 1'b1;
        step(); d_req = 1'b0; man_gnt = 1'b0;
        for (int w = 1; w <= 7; w++) begin
            @(negedge clk); check("tmo_early_err", {62'd0, err, d_rvalid}, 64'd0);
            step();
        end
        @(negedge clk); check("tmo_err_pulse", {62'd0, err, d_rvalid}, 64'd3);
        step();
        @(negedge clk); check("tmo_back_idle", {62'd0, busy, err}, 64'd0);
        step(); man_rvalid = 1'b1; man_rdata = 32'h77;
        @(negedge clk); check("tmo_late_ignored", {62'd0, i_rvalid, d_rvalid}, 64'd0);
        step(); man_rvalid = 1'b0;

        // response arriving exactly on the timeout cycle is a normal completion
        gnt_q.push_back(1'b1);
        r = '{1'b1, 32'hCAFE0001, 1'b1, 1'b0};
        rsp_q.push_back(r);
        step(); i_req = 1'b1; i_addr = 32'h140;
        step(); man_gnt = 1'b1;
        step(); i_req = 1'b0; man_gnt = 1'b0;
        for (int w = 1; w < 7; w++) step();
        step(); man_rvalid = 1'b1; man_rdata = 32'hCAFE0001;
        @(negedge clk); check("tie_no_err", {63'd0, err}, 64'd0);
        step(); man_rvalid = 1'b0;

        // asynchronous reset in the middle of WAIT
        gnt_q.push_back(1'b0);
        step(); d_req = 1'b1; d_addr = 32'h90;
        step(); man_gnt = 1'b1;
        step(); d_req = 1'b0; man_gnt = 1'b0;
        step();
        #2 rst_n = 1'b0;
        #1 check("async_reset_zero",
                 {63'd0, |{i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
                           m_req, m_we, m_be, m_addr, m_wdata, busy, err}}, 64'd0);
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        step(); man_rvalid = 1'b1; man_rdata = 32'h99;
        @(negedge clk); check("post_reset_stray", {61'd0, i_rvalid, d_rvalid, busy}, 64'd0);
        step(); man_rvalid = 1'b0;
        mem_auto = 1'b1;
        gnt_q.push_back(1'b1);
        r = '{1'b1, 32'hA5A5_0180, 1'b1, 1'b0};
        rsp_q.push_back(r);
        i_req = 1'b1; i_addr = 32'h180;
        for (int c = 0; c < 10 && !i_gnt; c++) @(negedge clk);
        check("post_reset_gnt", {63'd0, i_gnt}, 64'd1);
        step(); i_req = 1'b0;
        repeat (4) step();

        check("gnt_q_drained", 64'(gnt_q.size()), 64'd0);
        check("rsp_q_drained", 64'(rsp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
